decimator_mc: RTL and testbench
===============================

Name: decimator_mc

Overview:
- Multi-channel, runtime-programmable decimator; successor to the fixed-ratio, single-channel, free-running downsampler.
- Accepts CH parallel unsigned channels qualified by in_valid and emits one output frame per `ratio` accepted samples.
- Two modes: pick (last sample of the frame) or average (boxcar sum, shifted and saturated).
- Sits between sample sources (ADC/filter outputs) and lower-rate processing.

Parameters:
- DW, 8, bits per channel sample (unsigned)
- CH, 2, number of channels; data packed with channel k at [k*DW +: DW]
- RMAX, 16, maximum decimation ratio (>=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  data_in is a valid sample set this cycle
- data_in  in  CH*DW  packed input samples
- ratio  in  $clog2(RMAX+1)  requested decimation ratio; 0 treated as 1, values >RMAX clamp to RMAX
- mode  in  1  0 = pick, 1 = average
- shift  in  5  right shift applied to sum in average mode; values >$clog2(RMAX) clamp to $clog2(RMAX)
- sync_clr  in  1  restart frame
- data_out  out  CH*DW  packed decimated outputs
- out_valid  out  1  single-cycle pulse, data_out updated

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- State:
  - frame counter cnt, width $clog2(RMAX)
  - per-channel accumulator acc[k], AW = DW+$clog2(RMAX) bits
  - latched ratio_q, mode_q, shift_q
- Reset:
  - cnt=0, acc=0, data_out=0, out_valid=0.
  - ratio_q/mode_q/shift_q load from the (clamped) ports in the reset cycle.
- Parameter latching: ratio/mode/shift are sampled only at reset, at sync_clr, and at frame end. Mid-frame changes have no effect until the next frame boundary.
- Cycle with in_valid=0 and sync_clr=0: cnt, acc and data_out hold; out_valid=0.
- Cycle with in_valid=1 and cnt < ratio_q-1: cnt++, acc[k] += data_in[k]; out_valid=0.
- Cycle with in_valid=1 and cnt == ratio_q-1 (frame end):
  - pick: data_out[k] = data_in[k].
  - average: s = acc[k] + data_in[k]; r = s >> shift_q; data_out[k] = (r > 2^DW-1) ? 2^DW-1 : r[DW-1:0].
  - out_valid=1 next cycle (latency 1 clock from the final accepted sample).
  - cnt=0, acc=0; ratio_q/mode_q/shift_q reload from the ports.
- ratio_q == 1: every valid sample produces an output. Pick = 1-cycle registered passthrough; average = data_in >> shift_q.
- sync_clr=1: cnt=0, acc=0, parameters reload, out_valid=0, data_out holds. sync_clr has priority over in_valid; a sample presented in the same cycle is discarded.
- reset has priority over everything. Reset mid-frame discards the partial frame; no output is produced.
- out_valid never asserts on two consecutive cycles unless ratio_q==1 and in_valid is high continuously.
- All channels share cnt and all parameters; channels are fully independent arithmetically.
- Sum width: AW guarantees no accumulator overflow for RMAX samples of 2^DW-1.

Optional Feature:
- Macro: DECIM_ROUND_EN.
- When defined, average mode adds 2^(shift_q-1) to s before shifting when shift_q > 0 (round-half-up); saturation is applied after rounding. The rounding adder is AW+1 bits.
- When not defined, average mode truncates (plain shift); no rounding logic is built.
- Pick mode is identical either way.

Test Plan:
- Pick, ratio=4, CH=2, continuous in_valid, ch0 = 1,2,3,...; ch1 = 100+n -> out_valid pulses every 4th cycle; outputs (4,104), (8,108), (12,112); 1-cycle latency.
- Average, ratio=4, shift=2, ch0 samples 10,11,12,14 -> data_out ch0 = 11 (sum 47 truncated). With DECIM_ROUND_EN: 12.
- Average, ratio=16, shift=0, all samples 255 -> sum 4080 saturates, data_out = 255. Same with shift=4 -> 255 exactly.
- Gapped in_valid (valid every 3rd cycle), ratio=3 pick -> output only after 3 accepted samples (cycle 7 after first); data_out holds between pulses.
- Ratio change 4->2 mid-frame -> current frame completes at 4 samples, subsequent frames at 2. ratio=0 -> behaves as 1; ratio=31 (RMAX=16) -> behaves as 16.
- sync_clr asserted with in_valid after 2 of 4 samples -> no output, that sample dropped; next output after 4 further samples. Reset mid-frame -> outputs 0, no pulse.

Source files
------------

// File: rtl/decimator_mc.sv
`default_nettype none
// ============================================================================
// decimator_mc : multi-channel decimator, pick-last or boxcar-average per frame.
// Optional macro DECIM_ROUND_EN enables round-half-up in average mode.
// Revision: 1.0
// ============================================================================
module decimator_mc #(
  parameter int DW   = 8,
  parameter int CH   = 2,
  parameter int RMAX = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [CH*DW-1:0]          data_in,
  input  logic [$clog2(RMAX+1)-1:0] ratio,
  input  logic                      mode,
  input  logic [4:0]                shift,
  input  logic                      sync_clr,
  output logic [CH*DW-1:0]          data_out,
  output logic                      out_valid
);
  localparam int         RW   = $clog2(RMAX+1);
  localparam int         CW   = $clog2(RMAX);
  localparam int         AW   = DW + CW;
  localparam logic [4:0] SMAX = 5'(CW);
`ifdef DECIM_ROUND_EN
  localparam int         SHW  = AW + 1;
`else
  localparam int         SHW  = AW;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ratio_q, w_ratio_c;
  logic          mode_q;
  logic [4:0]    shift_q, w_shift_c;
  logic          out_valid_q;
  logic          w_last, w_reload;

  always_comb begin
    w_ratio_c = ratio;
    if (ratio == '0)
      w_ratio_c = RW'(1);
    else if (ratio > RW'(RMAX))
      w_ratio_c = RW'(RMAX);
    w_shift_c = (shift > SMAX) ? SMAX : shift;
    w_last    = in_valid && !sync_clr && (RW'(cnt_q) == ratio_q - RW'(1));
    w_reload  = sync_clr || w_last;
    cnt_d     = cnt_q;
    if (w_reload)
      cnt_d = '0;
    else if (in_valid)
      cnt_d = cnt_q + CW'(1);
  end

  // Parameters only move at reset, sync_clr and frame boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ratio_q     <= w_ratio_c;
      mode_q      <= mode;
      shift_q     <= w_shift_c;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= w_last;
      if (w_reload) begin
        ratio_q <= w_ratio_c;
        mode_q  <= mode;
        shift_q <= w_shift_c;
      end
    end
  end

  assign out_valid = out_valid_q;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0]  w_din;
    logic [AW-1:0]  acc_q;
    logic [AW-1:0]  w_sum;
    logic [SHW-1:0] w_shr;
    logic [DW-1:0]  w_avg;
    logic [DW-1:0]  dout_q;

    assign w_din = data_in[k*DW +: DW];
    assign w_sum = acc_q + AW'(w_din);
`ifdef DECIM_ROUND_EN
    logic [SHW-1:0] w_rnd;
    assign w_rnd = (shift_q == 5'd0) ? SHW'(w_sum)
                                     : SHW'(w_sum) + (SHW'(1) << (shift_q - 5'd1));
    assign w_shr = w_rnd >> shift_q;
`else
    assign w_shr = w_sum >> shift_q;
`endif
    assign w_avg = (w_shr > SHW'({DW{1'b1}})) ? {DW{1'b1}} : w_shr[DW-1:0];

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q  <= '0;
        dout_q <= '0;
      end else if (sync_clr) begin
        acc_q  <= '0;
      end else if (in_valid) begin
        if (w_last) begin
          acc_q  <= '0;
          dout_q <= mode_q ? w_avg : w_din;
        end else begin
          acc_q  <= w_sum;
        end
      end
    end

    assign data_out[k*DW +: DW] = dout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_decimator_mc.sv
`default_nettype none
// ============================================================================
// tb_decimator_mc : directed vector table plus randomized run against a
// queue-based frame model. Revision: 1.0
// ============================================================================
module tb_decimator_mc;
  localparam int DW = 8, CH = 2, RMAX = 16;
`ifdef DECIM_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0, in_valid = 1'b0, mode = 1'b0, sync_clr = 1'b0;
  logic [CH*DW-1:0] data_in = '0;
  logic [CH*DW-1:0] data_out;
  logic [4:0]       ratio = 5'd1, shift = 5'd0;
  logic             out_valid;

  always #5 clk = ~clk;

  decimator_mc #(.DW(DW), .CH(CH), .RMAX(RMAX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
    .ratio(ratio), .mode(mode), .shift(shift), .sync_clr(sync_clr),
    .data_out(data_out), .out_valid(out_valid)
  );

  typedef struct {
    int rst, iv, sc, r, m, s, d0, d1, eov, e0, e1;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic v(input int rst, iv, sc, r, m, s, d0, d1, eov, e0, e1);
    vec_t t;
    t = '{rst, iv, sc, r, m, s, d0, d1, eov, e0, e1};
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d required %0d", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input int rst, iv, sc, r, m, s, d0, d1);
    @(negedge clk);
    reset    = rst[0];
    in_valid = iv[0];
    sync_clr = sc[0];
    ratio    = 5'(r);
    mode     = m[0];
    shift    = 5'(s);
    data_in  = {8'(d1), 8'(d0)};
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_r(input int r);
    return (r == 0) ? 1 : ((r > RMAX) ? RMAX : r);
  endfunction

  function automatic int clamp_s(input int s);
    return (s > $clog2(RMAX)) ? $clog2(RMAX) : s;
  endfunction

  // Result of one completed frame, from the list of its samples.
  function automatic int reduce(input int q[$], input int md, input int s);
    int sum;
    if (md == 0) return q[q.size()-1];
    sum = 0;
    foreach (q[i]) sum += q[i];
    if (RND != 0 && s > 0) sum += 1 << (s - 1);
    sum = sum >> s;
    return (sum > 255) ? 255 : sum;
  endfunction

  initial begin
    int a0, a1, h;

    // Pick, ratio 4, continuous
    v(1,0,0,4,0,0,0,0, 0,0,0);
    for (int n = 1; n <= 12; n++) begin
      h = (n / 4) * 4;
      v(0,1,0,4,0,0,n,100+n, (n % 4 == 0), h, (h != 0) ? 100+h : 0);
    end
    // Average, ratio 4, shift 2
    a0 = RND ? 12 : 11;
    a1 = RND ? 202 : 201;
    v(1,0,0,4,1,2,0,0, 0,0,0);
    v(0,1,0,4,1,2,10,200, 0,0,0);
    v(0,1,0,4,1,2,11,201, 0,0,0);
    v(0,1,0,4,1,2,12,202, 0,0,0);
    v(0,1,0,4,1,2,14,203, 1,a0,a1);
    v(0,0,0,4,1,2,99,99,  0,a0,a1);
    // Average, ratio 16, saturation at shift 0 and exact at shift 4
    v(1,0,0,16,1,0,0,0, 0,0,0);
    for (int i = 0; i < 16; i++)
      v(0,1,0,16,1,0,255,1, (i == 15), (i == 15) ? 255 : 0, (i == 15) ? 16 : 0);
    v(1,0,0,16,1,4,0,0, 0,0,0);
    for (int i = 0; i < 16; i++)
      v(0,1,0,16,1,4,255,1, (i == 15), (i == 15) ? 255 : 0, (i == 15) ? 1 : 0);
    // Gapped valid, ratio 3 pick
    v(1,0,0,3,0,0,0,0, 0,0,0);
    for (int i = 0; i < 9; i++)
      v(0,(i % 3 == 0),0,3,0,0,20+i,60+i, (i == 6), (i >= 6) ? 26 : 0, (i >= 6) ? 66 : 0);
    // Ratio change 4 -> 2 mid-frame
    v(1,0,0,4,0,0,0,0, 0,0,0);
    v(0,1,0,4,0,0,1,51, 0,0,0);
    v(0,1,0,4,0,0,2,52, 0,0,0);
    v(0,1,0,2,0,0,3,53, 0,0,0);
    v(0,1,0,2,0,0,4,54, 1,4,54);
    v(0,1,0,2,0,0,5,55, 0,4,54);
    v(0,1,0,2,0,0,6,56, 1,6,56);
    v(0,1,0,2,0,0,7,57, 0,6,56);
    v(0,1,0,2,0,0,8,58, 1,8,58);
    // Ratio 0 behaves as 1
    v(1,0,0,0,0,0,0,0, 0,0,0);
    v(0,1,0,0,0,0,9,59,   1,9,59);
    v(0,1,0,0,0,0,10,60,  1,10,60);
    v(0,0,0,0,0,0,11,61,  0,10,60);
    v(1,0,0,0,1,1,0,0, 0,0,0);
    v(0,1,0,0,1,1,9,200,  1,RND ? 5 : 4,100);
    // Ratio 31 clamps to 16
    v(1,0,0,31,0,0,0,0, 0,0,0);
    for (int i = 0; i < 16; i++)
      v(0,1,0,31,0,0,i+1,i+200, (i == 15), (i == 15) ? 16 : 0, (i == 15) ? 215 : 0);
    // Shift 31 clamps to 4
    v(1,0,0,2,1,31,0,0, 0,0,0);
    v(0,1,0,2,1,31,255,16, 0,0,0);
    v(0,1,0,2,1,31,255,16, 1,RND ? 32 : 31,2);
    // sync_clr drops a sample and restarts; then reset mid-frame
    v(1,0,0,4,0,0,0,0, 0,0,0);
    for (int n = 1; n <= 4; n++)
      v(0,1,0,4,0,0,n,n+30, (n == 4), (n == 4) ? 4 : 0, (n == 4) ? 34 : 0);
    v(0,1,0,4,0,0,11,41, 0,4,34);
    v(0,1,0,4,0,0,12,42, 0,4,34);
    v(0,1,1,4,0,0,13,43, 0,4,34);
    v(0,1,0,4,0,0,14,44, 0,4,34);
    v(0,1,0,4,0,0,15,45, 0,4,34);
    v(0,1,0,4,0,0,16,46, 0,4,34);
    v(0,1,0,4,0,0,17,47, 1,17,47);
    v(0,1,0,4,0,0,18,48, 0,17,47);
    v(0,1,0,4,0,0,19,49, 0,17,47);
    v(1,1,0,4,0,0,20,50, 0,0,0);
    for (int n = 21; n <= 24; n++)
      v(0,1,0,4,0,0,n,n+30, (n == 24), (n == 24) ? 24 : 0, (n == 24) ? 54 : 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].sc, vecs[i].r, vecs[i].m, vecs[i].s,
            vecs[i].d0, vecs[i].d1);
      check("tbl_valid", i, 32'(out_valid), vecs[i].eov);
      check("tbl_ch0",   i, 32'(data_out[7:0]),  vecs[i].e0);
      check("tbl_ch1",   i, 32'(data_out[15:8]), vecs[i].e1);
    end

    // Randomized run against the frame model
    begin
      int q0[$], q1[$];
      int mr, mm, ms, eov, ed0, ed1;
      int rr, rm, rs;
      rr = 4; rm = 0; rs = 0;
      mr = 1; mm = 0; ms = 0; eov = 0; ed0 = 0; ed1 = 0;
      for (int c = 0; c < 3000; c++) begin
        int rst, iv, sc, d0, d1;
        rst = (c == 0) || ($urandom_range(0, 299) == 0);
        iv  = ($urandom_range(0, 9) < 6);
        sc  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 9) == 0) begin
          rr = $urandom_range(0, 20);
          rm = $urandom_range(0, 1);
          rs = $urandom_range(0, 6);
        end
        d0 = $urandom_range(0, 255);
        d1 = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
        eov = 0;
        if (rst != 0 || sc != 0) begin
          q0.delete(); q1.delete();
          mr = clamp_r(rr); mm = rm; ms = clamp_s(rs);
          if (rst != 0) begin ed0 = 0; ed1 = 0; end
        end else if (iv != 0) begin
          q0.push_back(d0); q1.push_back(d1);
          if (q0.size() == mr) begin
            ed0 = reduce(q0, mm, ms);
            ed1 = reduce(q1, mm, ms);
            eov = 1;
            q0.delete(); q1.delete();
            mr = clamp_r(rr); mm = rm; ms = clamp_s(rs);
          end
        end
        drive(rst, iv, sc, rr, rm, rs, d0, d1);
        check("rnd_valid", c, 32'(out_valid), eov);
        check("rnd_ch0",   c, 32'(data_out[7:0]),  ed0);
        check("rnd_ch1",   c, 32'(data_out[15:8]), ed1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
